// File: rtl/udp_pkg.sv
// udp_pkg: shared definitions for the UDP transmit-side blocks.
//   BYTE_W          - width of one payload byte on the transmit stream
//   udp_tx_state_t  - transmit FSM state encoding {IDLE, SEND}
//   udp_len_ok()    - true when a requested length fits 1..capacity bytes
package udp_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } udp_tx_state_t;

    // A packet must carry at least one byte and no more than the shadow register holds.
    function automatic logic udp_len_ok(input int unsigned len, input int unsigned capacity);
        return (len != 0) && (len <= capacity);
    endfunction

endpackage

// File: rtl/udp_writer.sv
// udp_writer: latches a packed payload word on a start pulse and streams it
// out one byte per valid/ready handshake, most-significant byte first.
//   clk, rst   - single clock, synchronous active-high reset
//   start      - one-cycle send request for i_data/i_len
//   i_data     - packed payload, byte CAPACITY-1 (top) is sent first
//   i_len      - bytes to send, 1..CAPACITY (top i_len bytes are used)
//   o_valid    - o_data holds a byte to transfer
//   o_data     - current payload byte
//   o_last     - marks the final byte of the packet
//   o_ready    - downstream accepts the byte this cycle
//   busy       - packet in progress, start is refused
//   error      - one-cycle pulse after a refused start
module udp_writer
    import udp_pkg::*;
#(
    parameter  int unsigned CAPACITY = 1,
    localparam int unsigned LEN_W    = $clog2(CAPACITY + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CAPACITY*BYTE_W-1:0]   i_data,
    input  logic [LEN_W-1:0]             i_len,
    output logic                         o_valid,
    output logic [BYTE_W-1:0]            o_data,
    output logic                         o_last,
    input  logic                         o_ready,
    output logic                         busy,
    output logic                         error
);

    localparam int unsigned DATA_W = CAPACITY * BYTE_W;

    udp_tx_state_t      state;
    logic [DATA_W-1:0]  shreg;
    logic [LEN_W-1:0]   cnt;

    logic [DATA_W-1:0]  shreg_next;
    logic               len_ok;
    logic               xfer;

    // Next shadow contents after a transfer, length check and handshake decode.
    always_comb begin
        shreg_next = shreg << BYTE_W;
        len_ok     = udp_len_ok(32'(i_len), CAPACITY);
        xfer       = o_valid && o_ready;
    end

    // FSM, shadow shift register, remaining-byte counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            // o_data is loaded with the top byte directly so the
                            // first byte is presented in the cycle after acceptance.
                            shreg   <= i_data;
                            cnt     <= i_len;
                            o_data  <= i_data[DATA_W-1 -: BYTE_W];
                            o_last  <= (i_len == LEN_W'(1));
                            o_valid <= 1'b1;
                            busy    <= 1'b1;
                            state   <= SEND;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    // A start in flight is refused even on the final handshake.
                    if (start) begin
                        error <= 1'b1;
                    end
                    if (xfer) begin
                        shreg <= shreg_next;
                        cnt   <= cnt - LEN_W'(1);
                        if (o_last) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_data  <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            o_data <= shreg_next[DATA_W-1 -: BYTE_W];
                            o_last <= (cnt == LEN_W'(2));
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/udp_writer.md
# udp_writer

Transmit-side counterpart of the UDP payload reader: latches a packed payload word of up to `CAPACITY` bytes on a start pulse and streams it out one byte per handshake, most-significant byte first, so a reader of the same `CAPACITY` reassembles the identical word. It sits between application logic and the UDP/MAC transmit path and owns the byte-valid/ready handshake toward that path.

## Interface
- `CAPACITY`, 1: maximum payload length in bytes (≥1).
- `LEN_W`, `$clog2(CAPACITY+1)`: width of the length input (localparam, not overridable).

- `clk`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to send the current `i_data`/`i_len`.
- `i_data`  in  `CAPACITY*8`  packed payload; byte k occupies bits `[(k+1)*8-1:k*8]`; byte `CAPACITY-1` is sent first.
- `i_len`  in  `LEN_W`  number of bytes to send, 1..`CAPACITY`.
- `o_valid`  out  1  `o_data` holds a byte to transfer.
- `o_data`  out  8  current payload byte.
- `o_last`  out  1  qualifies the final byte of the packet.
- `o_ready`  in  1  downstream accepts the byte this cycle.
- `busy`  out  1  packet in progress; `start` not accepted.
- `error`  out  1  single-cycle pulse on a rejected `start`.

## Operation
- States: `IDLE`, `SEND`.
- `IDLE`: `busy`=0, `o_valid`=0. On `start` with 1 ≤ `i_len` ≤ `CAPACITY`: copy `i_data` into a shadow shift register, load the remaining-byte counter with `i_len`, go to `SEND`.
- `start` with `i_len`=0 or `i_len`>`CAPACITY`: stay in `IDLE`, pulse `error` the next cycle, emit nothing.
- `SEND`: `o_valid`=1, `o_data` = top byte of the shadow register (the byte originally at `i_data[CAPACITY*8-1 -: 8]` for the first transfer), `o_last`=1 iff remaining count = 1.
- Transfer occurs when `o_valid && o_ready`: shift the register left by 8 (zero fill) and decrement the count. If `o_last` was set, return to `IDLE`.
- `start` while in `SEND`, including the cycle of the last handshake: ignored, `error` pulses the next cycle, and the packet in flight is unaffected.
- `i_data`/`i_len` are sampled only in the accepting cycle; later changes have no effect.
- Sending `i_len` < `CAPACITY` transmits the top `i_len` bytes; lower bytes are never emitted.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_last`=0, `busy`=0, `error`=0, state `IDLE`, shadow register and counter 0.
- `start` accepted at cycle N: `busy` and `o_valid` go high at N+1 with the first byte.
- One byte per cycle when `o_ready` is held high; a packet of L bytes occupies cycles N+1..N+L.
- Stall (`o_ready`=0): `o_valid`, `o_data` and `o_last` hold stable; no drop or duplication.
- After the last handshake at cycle M: `o_valid`, `o_last` and `busy` are 0 at M+1; the earliest accepted `start` is at M+1.
- `error` is registered: it is high exactly one cycle after the offending `start`.
- `rst` mid-packet: the next cycle shows the reset values; the partial packet is abandoned, with no `o_last`.
- `CAPACITY`=1: `o_last` is high on every emitted byte.

## Structure
- Shared package `udp_pkg`: `BYTE_W`=8 and the state enum `udp_tx_state_t` {`IDLE`, `SEND`}, for reuse by future UDP transmit blocks.
- Single flat module with no sub-module; the shift register, counter and FSM are small enough to stay inline.

## Test plan
- `CAPACITY`=4, `i_data`=32'hDEADBEEF, `i_len`=4, `o_ready`=1 → bytes DE,AD,BE,EF on consecutive cycles, with `o_last` only on EF and `busy` low the cycle after.
- Same packet with `o_ready` toggling 1,0,0,1,1,0,1 → same 4 bytes in order; outputs stable during each 0; exactly 4 handshakes.
- `i_len`=2 with i_data=32'h11223344 → bytes 11,22 with `o_last` on 22; bytes 33 and 44 never appear.
- `i_len`=0, then `i_len`=5 → `error` pulses one cycle each, `o_valid` stays 0, `busy` stays 0.
- `start` during the second byte of a packet → `error` pulse; the in-flight packet completes unchanged; `start` the cycle after the last handshake is accepted.
- `rst` asserted after the first handshake → all outputs return to reset values the next cycle; a new `start` then sends the full packet correctly.
